// File: rtl/ula_8_bits_sequencer.sv
// rtl/ula_8_bits_sequencer.sv - command/response sequencer driving an 8-bit ULA from an accumulator
// Optional feature: define ULA_SEQ_ZERO_FLAG_EN to add the RES_ZERO output.
module ula_8_bits_sequencer #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] ACC_RESET     = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [7:0] CMD_DATA,
  input  logic       CMD_USE_CARRY,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [7:0] RES_DATA,
  output logic       RES_COUT,
  output logic       ERR,
`ifdef ULA_SEQ_ZERO_FLAG_EN
  output logic       RES_ZERO,
`endif
  output logic [7:0] ULA_A,
  output logic [7:0] ULA_B,
  output logic [2:0] ULA_X,
  output logic       ULA_CIN,
  input  logic [7:0] ULA_S,
  input  logic       ULA_COUT
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b111;
  localparam logic [2:0] OP_ILL5 = 3'b101;
  localparam logic [2:0] OP_ILL6 = 3'b110;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state;
  logic [7:0] acc;
  logic       carry;
  logic [3:0] cnt;
  logic       ula_arith;

  // Commands are only taken while idle; responses must drain first.
  assign CMD_READY = (state == IDLE);

  // Only ADD/SUB produce a meaningful carry/borrow; logic ops clear the flag.
  assign ula_arith = (ULA_X == OP_ADD) || (ULA_X == OP_SUB);

  // Sequencer FSM: accept, hold ULA inputs for the settle window, capture, respond.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= ACC_RESET;
      carry     <= 1'b0;
      cnt       <= 4'd0;
      RES_VALID <= 1'b0;
      RES_DATA  <= 8'h00;
      RES_COUT  <= 1'b0;
      ERR       <= 1'b0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
      RES_ZERO  <= 1'b0;
`endif
      ULA_A     <= 8'h00;
      ULA_B     <= 8'h00;
      ULA_X     <= 3'b000;
      ULA_CIN   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            if (CMD_OP == OP_LOAD) begin
              acc       <= CMD_DATA;
              carry     <= 1'b0;
              ERR       <= 1'b0;
              RES_DATA  <= CMD_DATA;
              RES_COUT  <= 1'b0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
              RES_ZERO  <= (CMD_DATA == 8'h00);
`endif
              RES_VALID <= 1'b1;
              state     <= RESP;
            end else if ((CMD_OP == OP_ILL5) || (CMD_OP == OP_ILL6)) begin
              ERR       <= 1'b1;
              RES_DATA  <= acc;
              RES_COUT  <= carry;
`ifdef ULA_SEQ_ZERO_FLAG_EN
              RES_ZERO  <= (acc == 8'h00);
`endif
              RES_VALID <= 1'b1;
              state     <= RESP;
            end else begin
              ULA_A   <= acc;
              ULA_B   <= CMD_DATA;
              ULA_X   <= CMD_OP;
              ULA_CIN <= CMD_USE_CARRY & carry;
              cnt     <= SETTLE_INIT;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            acc       <= ULA_S;
            carry     <= ula_arith & ULA_COUT;
            ERR       <= 1'b0;
            RES_DATA  <= ULA_S;
            RES_COUT  <= ula_arith & ULA_COUT;
`ifdef ULA_SEQ_ZERO_FLAG_EN
            RES_ZERO  <= (ULA_S == 8'h00);
`endif
            RES_VALID <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          RES_VALID <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
